// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, serializer-driven data bits, optional parity, stop bit.
// TX_OUT is decoded from the registered state, plus ser_data while in DATA.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  tx_done,
  output logic                  tx_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          par_bit;
  logic          par_en_q;
  logic          data_last;
  logic          timeout;

  // The data phase ends on ser_done, or on the last count as a fallback.
  assign data_last = ser_done || (cnt == CW'(DATA_WIDTH - 1));
  assign timeout   = (state == DATA) && !ser_done && (cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tx_err <= timeout;
      if (state == IDLE && Data_Valid) begin
        par_en_q <= PAR_EN;
        par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
      end
      if (state == START) begin
        cnt <= '0;
      end else if (state == DATA) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ser_en    = 1'b0;
    busy      = 1'b1;
    TX_OUT    = 1'b1;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (Data_Valid) state_nxt = START;
      end
      START: begin
        TX_OUT    = 1'b0;
        state_nxt = DATA;
      end
      DATA: begin
        ser_en = 1'b1;
        TX_OUT = ser_data;
        if (data_last) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        TX_OUT    = par_bit;
        state_nxt = STOP;
      end
      STOP: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a simple LSB-first serializer model.
module tb_uart_tx_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          ser_data;
  logic          ser_done;
  logic          ser_en;
  logic          busy;
  logic          TX_OUT;
  logic          tx_done;
  logic          tx_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Serializer model: loads while busy is low, shifts LSB first while enabled.
  logic [DW-1:0] shreg;
  int            idx;
  logic          done_en;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!busy) begin
      shreg <= P_DATA;
      idx   <= 0;
    end else if (ser_en) begin
      idx <= idx + 1;
    end
  end

  assign ser_data = (idx < DW) ? shreg[idx] : 1'b1;
  assign ser_done = done_en && ser_en && (idx == DW - 1);

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Sends one frame from IDLE and checks every cycle; returns one cycle into IDLE.
  task automatic frame(input logic [DW-1:0] byte_in, input logic pen, input logic ptyp,
                       input logic exp_par, input logic hold, input logic toggle,
                       input logic tmo);
    logic [15:0] exp;
    int          len;
    len = pen ? DW + 3 : DW + 2;
    exp = '1;
    exp[0] = 1'b0;
    for (int b = 0; b < DW; b++) exp[b+1] = byte_in[b];
    if (pen) exp[DW+1] = exp_par;
    P_DATA     = byte_in;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    check("idle_busy", busy, 1'b0);
    check("idle_tx", TX_OUT, 1'b1);
    step();
    Data_Valid = hold;
    for (int i = 0; i < len; i++) begin
      check($sformatf("tx_bit%0d", i), TX_OUT, exp[i]);
      check($sformatf("busy%0d", i), busy, 1'b1);
      check($sformatf("ser_en%0d", i), ser_en, (i >= 1 && i <= DW));
      check($sformatf("tx_done%0d", i), tx_done, (i == len - 1));
      check($sformatf("tx_err%0d", i), tx_err, (tmo && i == DW + 1));
      if (toggle && i == 3) begin
        PAR_TYP = ~PAR_TYP;
        PAR_EN  = ~PAR_EN;
        P_DATA  = ~P_DATA;
      end
      step();
    end
    check("post_busy", busy, 1'b0);
    check("post_tx", TX_OUT, 1'b1);
    check("post_err", tx_err, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    done_en    = 1'b1;
    #12;
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Idle line after reset
    for (int i = 0; i < 5; i++) begin
      check("idle5_tx", TX_OUT, 1'b1);
      check("idle5_busy", busy, 1'b0);
      check("idle5_ser_en", ser_en, 1'b0);
      step();
    end

    // 0xA5, no parity: line 0,1,0,1,0,0,1,0,1,1
    frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // 0x07 with even then odd parity, parity inputs toggled mid-frame
    frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // Data_Valid held high: back-to-back frames with a single idle cycle
    frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    Data_Valid = 1'b0;
    step();
    check("b2b_end_busy", busy, 1'b0);

    // Serializer never signals done: timeout path
    done_en = 1'b0;
    frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    done_en = 1'b1;
    step();

    // Reset during the 4th data bit
    P_DATA     = 8'hF0;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_ser_en", ser_en, 1'b1);
    check("pre_rst_tx", TX_OUT, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_tx", TX_OUT, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_ser_en", ser_en, 1'b0);
    check("arst_done", tx_done, 1'b0);
    step();
    check("arst_done2", tx_done, 1'b0);
    check("arst_err2", tx_err, 1'b0);
    rst_n = 1'b1;
    step();
    frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
